mux_scan_reader: RTL
====================

# mux_scan_reader

- Reading end of the `datamux` interface.
- Drives `SEL` through all four settings, waits a programmable settle time at each, and captures the two 4-bit `D_OUT1`/`D_OUT0` digits.
- Presents the eight captured digits as one atomic 32-bit frame with a valid pulse.
- Sits between `datamux` and the VGA character/digit renderer; the renderer consumes only whole, consistent frames.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 2: cycles `SEL` is held per slot before capture; legal range 1..255.
- `DIGIT_W`, default 4: digit width; `FRAME` is 8·`DIGIT_W` bits wide.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  begin a scan; sampled only in IDLE.
- `CONTINUOUS`  in  1  rescan immediately after a frame completes.
- `SEL`  out  2  select driven to `datamux`.
- `D_OUT1`  in  `DIGIT_W`  high digit from `datamux`.
- `D_OUT0`  in  `DIGIT_W`  low digit from `datamux`.
- `BUSY`  out  1  high whenever state ≠ IDLE.
- `FRAME`  out  8·`DIGIT_W`  last complete frame. Slot n occupies:
  - `FRAME[8n+7:8n+4]` ← `D_OUT1`
  - `FRAME[8n+3:8n]` ← `D_OUT0`
- `FRAME_VALID`  out  1  one-cycle pulse when `FRAME` updates.
- `FRAME_CHANGED`  out  1  one-cycle pulse, coincident with `FRAME_VALID`, only if the new frame ≠ the previous `FRAME`.

## Operation

States: IDLE, SCAN.

IDLE:
- `SEL`=0; settle counter=0.
- `START`=1 → SCAN with `SEL`=0.

SCAN:
- Settle counter increments every cycle.
- On the edge where counter = `SETTLE_CYCLES`-1:
  - Capture `D_OUT1`/`D_OUT0` into shadow slot `SEL`.
  - Reset counter to 0.
  - If `SEL` < 3: `SEL` ← `SEL`+1.
  - If `SEL` = 3: complete the frame (below).

Frame completion, all on the same edge:
- `FRAME` ← shadow slots 0–2 plus the slot-3 data being captured; no partial frame is ever visible.
- `FRAME_VALID` ← 1.
- `FRAME_CHANGED` ← (new ≠ old).
- Next state: `CONTINUOUS`=1 → SCAN with `SEL`=0; `CONTINUOUS`=0 → IDLE.

Boundary conditions:
- `START` while BUSY: ignored, no queuing.
- `CONTINUOUS` is sampled only at slot-3 capture. Deasserting it mid-scan finishes the current frame, then stops.
- `SEL` wraps 3→0 only via frame completion; it never takes other values.
- `RST` mid-scan:
  - State → IDLE; counter cleared.
  - Shadow contents are discarded and never published.
- First frame after reset: `FRAME_CHANGED` compares against 0.

Reset values: `SEL`=0, `BUSY`=0, `FRAME`=0, `FRAME_VALID`=0, `FRAME_CHANGED`=0.

## Timing

- `START` sampled at edge t → `BUSY`=1 and `SEL`=0 from t+1.
- Slot n is captured at edge t+(n+1)·`SETTLE_CYCLES`.
  - `SEL`=n is held exactly `SETTLE_CYCLES` cycles before its capture edge.
- `FRAME`/`FRAME_VALID` are updated at edge t+4·`SETTLE_CYCLES`.
  - With default 2: `FRAME_VALID` is high during cycle t+8..t+9.
- Continuous mode: frames every 4·`SETTLE_CYCLES` cycles, no gap cycle. `SEL` returns to 0 in the cycle `FRAME_VALID` is high.
- Single-shot: `BUSY` falls in the same cycle `FRAME_VALID` is high.
- `D_OUT*` must be stable by the end of the final settle cycle. `datamux` is combinational, so `SETTLE_CYCLES`=1 is legal.
- All outputs are registered; no combinational input-to-output path.

## Structure

- Shared package `vga_mux_pkg`:
  - `NUM_SLOTS`=4, `SEL_W`=2
  - state enum (IDLE, SCAN)
  - slot-to-frame bit-offset function
- One sub-module, `settle_timer`:
  - Loadable down-counter producing a one-cycle `done` strobe.
  - Parameterized by `SETTLE_CYCLES`.
  - Reusable by other scan blocks in the VGA path.

## Test plan

Bench model: `D_OUT1` = 2·`SEL`+1, `D_OUT0` = 2·`SEL`.

- Single-shot `START`, default params:
  - `SEL` steps 0,1,2,3 for two cycles each.
  - `FRAME`=32'h76543210, 8 cycles after the `START` edge.
  - `FRAME_VALID` and `FRAME_CHANGED` pulse once; `BUSY` drops the same cycle.
- `CONTINUOUS`=1 with static model data:
  - Second frame arrives 8 cycles after the first.
  - `FRAME_VALID`=1 and `FRAME_CHANGED`=0 on the second frame.
- Model output XOR 4'hF during slot 2 of frame 2 only:
  - `FRAME`=32'h76AB3210.
  - `FRAME_CHANGED`=1.
- `START` re-pulsed at cycles 3 and 5 of a scan:
  - Exactly one `FRAME_VALID`.
  - Timing identical to the single-shot case.
- `RST` at slot-2 settle:
  - All outputs return to reset values next cycle; `FRAME` stays 0.
  - A new `START` produces 32'h76543210 with full latency.
- `SETTLE_CYCLES`=1:
  - `SEL` changes every cycle.
  - `FRAME_VALID` 4 cycles after `START`.
  - Continuous frames every 4 cycles.

Source files
------------

// File: rtl/vga_mux_pkg.sv
// vga_mux_pkg: shared slot constants, scan state encoding and frame layout helper for the VGA path
package vga_mux_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, SCAN} state_t;
  function automatic int slot_offset(input int slot, input int digit_w);
    return slot * 2 * digit_w;
  endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: reloading down-counter that strobes done on the last of SETTLE_CYCLES enabled cycles
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam logic [7:0] TOP = 8'(SETTLE_CYCLES - 1);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (rst || load) cnt <= TOP;
    else if (en) cnt <= cnt == 8'd0 ? TOP : cnt - 8'd1;
  assign done = en && !load && cnt == 8'd0;
endmodule

// File: rtl/mux_scan_reader.sv
// mux_scan_reader: scans the four datamux slots and publishes them as one atomic frame with valid/changed pulses
module mux_scan_reader
  import vga_mux_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DIGIT_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 CONTINUOUS,
  output logic [SEL_W-1:0]     SEL,
  input  logic [DIGIT_W-1:0]   D_OUT1,
  input  logic [DIGIT_W-1:0]   D_OUT0,
  output logic                 BUSY,
  output logic [8*DIGIT_W-1:0] FRAME,
  output logic                 FRAME_VALID,
  output logic                 FRAME_CHANGED
);
  localparam int SLOT_W = 2 * DIGIT_W;
  state_t state, nxt;
  logic done, last;
  logic [SLOT_W-1:0] shadow [NUM_SLOTS];
  logic [8*DIGIT_W-1:0] next_frame;
  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk (CLK),
    .rst (RST),
    .load(state == IDLE),
    .en  (state == SCAN),
    .done(done)
  );
  assign last = done && SEL == SEL_W'(NUM_SLOTS - 1);
  assign BUSY = state != IDLE;
  always_ff @(posedge CLK) state <= RST ? IDLE : nxt;
  always_comb nxt = state == IDLE ? (START ? SCAN : IDLE) : (last && !CONTINUOUS ? IDLE : SCAN);
  always_comb begin
    next_frame = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      next_frame[slot_offset(i, DIGIT_W) +: SLOT_W] = i == NUM_SLOTS - 1 ? {D_OUT1, D_OUT0} : shadow[i];
  end
  always_ff @(posedge CLK)
    if (RST) begin
      SEL <= '0;
      FRAME <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_CHANGED <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= '0;
    end else begin
      SEL <= state == IDLE ? '0 : done ? SEL + SEL_W'(1) : SEL;
      if (done) shadow[SEL] <= {D_OUT1, D_OUT0};
      if (last) FRAME <= next_frame;
      FRAME_VALID <= last;
      FRAME_CHANGED <= last && next_frame != FRAME;
    end
endmodule
